// File: rtl/p08_spi_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : p08_spi_wr_pkg
// Brief   : Shared types and constants for the SPI register-write initiator.
// Revision: 1.0
// ============================================================================
package p08_spi_wr_pkg;

    localparam int CMD_W_DEF  = 4;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        HOLD = 3'd3,
        GAP  = 3'd4
    } state_t;

    // raybox-zero general-register command codes
    localparam logic [CMD_W_DEF-1:0] c_CMD_SKY     = 4'd0;
    localparam logic [CMD_W_DEF-1:0] c_CMD_FLOOR   = 4'd1;
    localparam logic [CMD_W_DEF-1:0] c_CMD_LEAK    = 4'd2;
    localparam logic [CMD_W_DEF-1:0] c_CMD_OTHER   = 4'd3;
    localparam logic [CMD_W_DEF-1:0] c_CMD_VSHIFT  = 4'd4;
    localparam logic [CMD_W_DEF-1:0] c_CMD_VINF    = 4'd5;
    localparam logic [CMD_W_DEF-1:0] c_CMD_MAPD    = 4'd6;
    localparam logic [CMD_W_DEF-1:0] c_CMD_TEXADD0 = 4'd7;
    localparam logic [CMD_W_DEF-1:0] c_CMD_TEXADD1 = 4'd8;
    localparam logic [CMD_W_DEF-1:0] c_CMD_TEXADD2 = 4'd9;
    localparam logic [CMD_W_DEF-1:0] c_CMD_TEXADD3 = 4'd10;

endpackage
`default_nettype wire

// File: rtl/p08_spi_phase_tick.sv
`default_nettype none
// ============================================================================
// Module  : p08_spi_phase_tick
// Brief   : CLK_DIV-cycle phase counter with terminal and pre-terminal pulses.
// Revision: 1.0
// ============================================================================
module p08_spi_phase_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick,
    output logic o_near
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_CNT_W'(CLK_DIV - 1));
    // o_near lets the owner register an output that must coincide with o_tick
    assign o_near = (r_cnt == c_CNT_W'(CLK_DIV - 2));

endmodule
`default_nettype wire

// File: rtl/p08_spi_reg_writer.sv
`default_nettype none
// ============================================================================
// Module  : p08_spi_reg_writer
// Brief   : SPI mode-0 initiator serialising {cmd, payload} register writes.
//           Optional 2-entry request FIFO: define P08_SPI_WR_QUEUE_EN.
// Revision: 1.0
// ============================================================================
module p08_spi_reg_writer
    import p08_spi_wr_pkg::*;
#(
    parameter int CMD_W   = CMD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = 5,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_SR_W  = CMD_W + DATA_W;
    localparam int c_BIT_W = $clog2(c_SR_W + 1);

    state_t              r_state;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_BIT_W-1:0]  r_bits;
    logic                r_csb;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_busy;
    logic                r_done;
    logic                r_idle;

    logic [CMD_W-1:0]    w_src_cmd;
    logic [DATA_W-1:0]   w_src_data;
    logic [LEN_W-1:0]    w_src_len;
    logic                w_avail;
    logic                w_take;
    logic                w_tick;
    logic                w_near;

`ifdef P08_SPI_WR_QUEUE_EN
    logic [CMD_W-1:0]    r_q_cmd  [2];
    logic [DATA_W-1:0]   r_q_data [2];
    logic [LEN_W-1:0]    r_q_len  [2];
    logic [1:0]          r_q_count;
    logic                r_q_rd;
    logic                r_q_wr;
    logic                w_push;

    assign o_ready = (r_q_count != 2'd2);
    assign w_push  = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q_count <= 2'd0;
            r_q_rd    <= 1'b0;
            r_q_wr    <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_cmd[r_q_wr]  <= i_cmd;
                r_q_data[r_q_wr] <= i_data;
                r_q_len[r_q_wr]  <= i_len;
                r_q_wr           <= ~r_q_wr;
            end
            if (w_take) begin
                r_q_rd <= ~r_q_rd;
            end
            case ({w_push, w_take})
                2'b10:   r_q_count <= r_q_count + 2'd1;
                2'b01:   r_q_count <= r_q_count - 2'd1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    assign w_src_cmd  = r_q_cmd[r_q_rd];
    assign w_src_data = r_q_data[r_q_rd];
    assign w_src_len  = r_q_len[r_q_rd];
    assign w_avail    = (r_q_count != 2'd0);
`else
    assign o_ready    = r_idle;
    assign w_src_cmd  = i_cmd;
    assign w_src_data = i_data;
    assign w_src_len  = i_len;
    assign w_avail    = i_valid && r_idle;
`endif

    // A frame starts from IDLE, or back-to-back straight out of GAP when queued
    assign w_take = w_avail && (r_idle || ((r_state == GAP) && w_tick));

    logic [LEN_W-1:0]   w_len_c;
    logic [c_BIT_W-1:0] w_n;
    logic [c_BIT_W-1:0] w_shamt;
    logic [c_SR_W-1:0]  w_load;

    assign w_len_c = (w_src_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : w_src_len;
    assign w_n     = c_BIT_W'(CMD_W) + c_BIT_W'(w_len_c);
    assign w_shamt = c_BIT_W'(DATA_W) - c_BIT_W'(w_len_c);
    assign w_load  = {w_src_cmd, w_src_data << w_shamt};

    p08_spi_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (r_idle),
        .o_tick  (w_tick),
        .o_near  (w_near)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bits  <= '0;
            r_csb   <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_take) begin
                r_state <= LO;
                r_sr    <= w_load;
                r_bits  <= w_n;
                r_csb   <= 1'b0;
                r_sclk  <= 1'b0;
                r_mosi  <= w_load[c_SR_W-1];
                r_busy  <= 1'b1;
                r_idle  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                    end
                    LO: begin
                        if (w_tick) begin
                            r_state <= HI;
                            r_sclk  <= 1'b1;
                        end
                    end
                    HI: begin
                        if (w_tick) begin
                            r_sclk <= 1'b0;
                            if (r_bits > c_BIT_W'(1)) begin
                                r_sr    <= r_sr << 1;
                                r_bits  <= r_bits - 1'b1;
                                r_mosi  <= r_sr[c_SR_W-2];
                                r_state <= LO;
                            end else begin
                                r_bits  <= '0;
                                r_mosi  <= 1'b0;
                                r_state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (w_tick) begin
                            r_state <= GAP;
                            r_csb   <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (w_near) begin
                            r_done <= 1'b1;
                        end
                        if (w_tick) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_idle  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_csb   <= 1'b1;
                        r_sclk  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_csb  = r_csb;
    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
`default_nettype wire
